vga_sync_interface: RTL and testbench

// - Display-side end of the ADDRH/ADDRV -> Colour pixel interface used by the snake controller.
// - Generates 640x480@60 Hz VGA timing from the 100 MHz CLK and publishes the current pixel address (ADDRH/ADDRV).
// - Samples the 12-bit colour returned for that address and drives the blanked colour and HS/VS to the VGA connector.
// - Sits between the snake controller and the board VGA pins.

---
 rtl/vga_timing_pkg.sv | 26 ++
 rtl/vga_timing_counter.sv | 37 +++
 rtl/vga_sync_interface.sv | 138 +++++++++++++
 tb/tb_vga_sync_interface.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 Hz VGA timing constants for the pixel interface.
package vga_timing_pkg;

  // Pixel clock divider: 100 MHz CLK -> 25 MHz pixel rate.
  localparam int unsigned CLK_DIV = 4;

  // Horizontal timing, in pixels.
  localparam int unsigned H_TOTAL = 800;
  localparam int unsigned H_PULSE = 96;
  localparam int unsigned H_BP    = 48;
  localparam int unsigned H_DISP  = 640;

  // Vertical timing, in lines.
  localparam int unsigned V_TOTAL = 521;
  localparam int unsigned V_PULSE = 2;
  localparam int unsigned V_BP    = 29;
  localparam int unsigned V_DISP  = 480;

  // First visible count on each axis.
  localparam int unsigned H_VIS_START = H_PULSE + H_BP;
  localparam int unsigned V_VIS_START = V_PULSE + V_BP;

  localparam int unsigned COLOUR_W = 12;
  localparam int unsigned CNT_W    = 10;

endpackage

// File: rtl/vga_timing_counter.sv
// Wrapping 0..MAX counter with enable; WRAP flags the terminal count.
module vga_timing_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned MAX   = H_TOTAL - 1,
  parameter int unsigned WIDTH = CNT_W
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             EN,
  output logic [WIDTH-1:0] COUNT,
  output logic             WRAP
);

  logic [WIDTH-1:0] count_q, count_d;

  assign WRAP  = (count_q == WIDTH'(MAX));
  assign COUNT = count_q;

  // Next count: advance on enable, returning to 0 after MAX.
  always_comb begin
    count_d = count_q;
    if (EN) begin
      count_d = WRAP ? '0 : count_q + WIDTH'(1);
    end
  end

  // Count register.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/vga_sync_interface.sv
// VGA timing generator: publishes the pixel address, samples the returned colour
// one pixel later and drives blanked colour with sync aligned to it.
module vga_sync_interface
  import vga_timing_pkg::*;
#(
  parameter int unsigned HTotal = H_TOTAL,
  parameter int unsigned HPulse = H_PULSE,
  parameter int unsigned HBp    = H_BP,
  parameter int unsigned HDisp  = H_DISP,
  parameter int unsigned VTotal = V_TOTAL,
  parameter int unsigned VPulse = V_PULSE,
  parameter int unsigned VBp    = V_BP,
  parameter int unsigned VDisp  = V_DISP
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic [COLOUR_W-1:0] COLOUR_IN,
  output logic [9:0]          ADDRH,
  output logic [8:0]          ADDRV,
  output logic                DISP_EN,
  output logic                FRAME_START,
  output logic                HS,
  output logic                VS,
  output logic [COLOUR_W-1:0] COLOUR_OUT
);

  localparam logic [CNT_W-1:0] HPulseC   = CNT_W'(HPulse);
  localparam logic [CNT_W-1:0] VPulseC   = CNT_W'(VPulse);
  localparam logic [CNT_W-1:0] HVisStart = CNT_W'(HPulse + HBp);
  localparam logic [CNT_W-1:0] HVisEnd   = CNT_W'(HPulse + HBp + HDisp);
  localparam logic [CNT_W-1:0] VVisStart = CNT_W'(VPulse + VBp);
  localparam logic [CNT_W-1:0] VVisEnd   = CNT_W'(VPulse + VBp + VDisp);

  logic [1:0]       div_q;
  logic             pix_tick;
  logic             run_q;
  logic             tick;
  logic [CNT_W-1:0] h_count, v_count;
  logic             h_wrap, v_wrap;

  logic             hvis, vvis;
  logic [9:0]       addr_h_d;
  logic [8:0]       addr_v_d;

  logic [9:0]          addr_h_q;
  logic [8:0]          addr_v_q;
  logic                disp_en_q, frame_start_q, hs_s1_q, vs_s1_q;
  logic                hs_q, vs_q;
  logic [COLOUR_W-1:0] colour_q;

  assign pix_tick = (div_q == 2'(CLK_DIV - 1));
  // The first divider wrap after reset only arms the timing, so counting starts at 0.
  assign tick     = pix_tick & run_q;

  // Pixel divider and run flag.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      div_q <= '0;
      run_q <= 1'b0;
    end else begin
      div_q <= pix_tick ? 2'd0 : div_q + 2'd1;
      run_q <= run_q | pix_tick;
    end
  end

  vga_timing_counter #(
    .MAX   (HTotal - 1),
    .WIDTH (CNT_W)
  ) u_h_counter (
    .CLK   (CLK),
    .RESET (RESET),
    .EN    (tick),
    .COUNT (h_count),
    .WRAP  (h_wrap)
  );

  vga_timing_counter #(
    .MAX   (VTotal - 1),
    .WIDTH (CNT_W)
  ) u_v_counter (
    .CLK   (CLK),
    .RESET (RESET),
    .EN    (tick & h_wrap),
    .COUNT (v_count),
    .WRAP  (v_wrap)
  );

  // Visible-window decode and address offsets from the current counts.
  always_comb begin
    hvis     = (h_count >= HVisStart) && (h_count < HVisEnd);
    vvis     = (v_count >= VVisStart) && (v_count < VVisEnd);
    addr_h_d = hvis ? 10'(h_count - HVisStart) : 10'd0;
    addr_v_d = vvis ? 9'(v_count - VVisStart) : 9'd0;
  end

  // Stage 1: address, display enable and sync, plus the one-CLK frame pulse.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      addr_h_q      <= '0;
      addr_v_q      <= '0;
      disp_en_q     <= 1'b0;
      hs_s1_q       <= 1'b1;
      vs_s1_q       <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      frame_start_q <= tick & (h_count == '0) & (v_count == '0);
      if (tick) begin
        addr_h_q  <= addr_h_d;
        addr_v_q  <= addr_v_d;
        disp_en_q <= hvis & vvis;
        hs_s1_q   <= (h_count >= HPulseC);
        vs_s1_q   <= (v_count >= VPulseC);
      end
    end
  end

  // Stage 2: sample the consumer's colour and delay sync to stay aligned with it.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      colour_q <= '0;
      hs_q     <= 1'b1;
      vs_q     <= 1'b1;
    end else if (tick) begin
      colour_q <= disp_en_q ? COLOUR_IN : '0;
      hs_q     <= hs_s1_q;
      vs_q     <= vs_s1_q;
    end
  end

  assign ADDRH       = addr_h_q;
  assign ADDRV       = addr_v_q;
  assign DISP_EN     = disp_en_q;
  assign FRAME_START = frame_start_q;
  assign HS          = hs_q;
  assign VS          = vs_q;
  assign COLOUR_OUT  = colour_q;

endmodule

// File: tb/tb_vga_sync_interface.sv
// Directed bench for vga_sync_interface with full horizontal timing and a short frame
// (9 lines: 2 sync, 1 back porch, 5 visible, 1 front porch).
module tb_vga_sync_interface;

  localparam int unsigned HT  = 800;
  localparam int unsigned HP  = 96;
  localparam int unsigned HVS = 144;
  localparam int unsigned HD  = 640;
  localparam int unsigned VT  = 9;
  localparam int unsigned VP  = 2;
  localparam int unsigned VVS = 3;
  localparam int unsigned VD  = 5;
  localparam int unsigned FRAME_PIX = HT * VT;                    // 7200 pixels
  localparam int unsigned C_SWITCH  = 4 * (2 + FRAME_PIX + 10);   // early frame 1, blanked
  localparam int unsigned C_RST     = 4 * (2 + 2 * FRAME_PIX + 3 * HT + 400) + 1; // (400,3)

  logic        clk;
  logic        rst_n;
  logic [11:0] colour_in;
  logic [9:0]  addrh;
  logic [8:0]  addrv;
  logic        disp_en, frame_start, hs, vs;
  logic [11:0] colour_out;
  bit          block_mode;

  int unsigned n_tests;
  int unsigned n_fail;

  vga_sync_interface #(
    .VTotal (VT),
    .VPulse (VP),
    .VBp    (1),
    .VDisp  (VD)
  ) u_dut (
    .CLK         (clk),
    .RESET       (rst_n),
    .COLOUR_IN   (colour_in),
    .ADDRH       (addrh),
    .ADDRV       (addrv),
    .DISP_EN     (disp_en),
    .FRAME_START (frame_start),
    .HS          (hs),
    .VS          (vs),
    .COLOUR_OUT  (colour_out)
  );

  always #5 clk = ~clk;

  // Model consumer: solid red, or cyan with a black 4x4 block at columns 80..83, rows 0..3.
  function automatic logic [11:0] consumer(input logic [9:0] ah, input logic [8:0] av,
                                           input bit blk);
    if (!blk) return 12'hF00;
    return (ah[9:2] == 8'd20 && av[8:2] == 7'd0) ? 12'h000 : 12'h0FF;
  endfunction

  assign colour_in = consumer(addrh, addrv, block_mode);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_addrh"},  32'(addrh), 32'd0);
    check({tag, "_addrv"},  32'(addrv), 32'd0);
    check({tag, "_de"},     32'(disp_en), 32'd0);
    check({tag, "_fs"},     32'(frame_start), 32'd0);
    check({tag, "_hs"},     32'(hs), 32'd1);
    check({tag, "_vs"},     32'(vs), 32'd1);
    check({tag, "_colour"}, 32'(colour_out), 32'd0);
  endtask

  // c = rising edges since reset release; ticks land on edges 4, 8, ...; the first only arms.
  task automatic check_cycle(input int unsigned c);
    int unsigned n, p, q, h, v, hq, vq;
    logic [31:0] e_de, e_ah, e_av, e_fs, e_hs, e_vs, e_col;
    bit hv, vv;
    n = c / 4;
    e_de = 0; e_ah = 0; e_av = 0; e_fs = 0; e_hs = 1; e_vs = 1; e_col = 0;
    if (n >= 2) begin
      p  = n - 2;
      h  = p % HT;
      v  = (p / HT) % VT;
      hv = (h >= HVS) && (h < HVS + HD);
      vv = (v >= VVS) && (v < VVS + VD);
      e_de = 32'(hv && vv);
      e_ah = hv ? h - HVS : 0;
      e_av = vv ? v - VVS : 0;
      e_fs = 32'((c % 4 == 0) && h == 0 && v == 0);
    end
    if (n >= 3) begin
      q  = n - 3;
      hq = q % HT;
      vq = (q / HT) % VT;
      e_hs = 32'(hq >= HP);
      e_vs = 32'(vq >= VP);
      if (hq >= HVS && hq < HVS + HD && vq >= VVS && vq < VVS + VD)
        e_col = 32'(consumer(10'(hq - HVS), 9'(vq - VVS), block_mode));
    end
    check("addrh",  32'(addrh), e_ah);
    check("addrv",  32'(addrv), e_av);
    check("de",     32'(disp_en), e_de);
    check("fs",     32'(frame_start), e_fs);
    check("hs",     32'(hs), e_hs);
    check("vs",     32'(vs), e_vs);
    check("colour", 32'(colour_out), e_col);
  endtask

  initial begin
    int unsigned hs_fall, vs_fall, de_rise, fs_last, fs_first;
    logic p_hs, p_vs, p_de;
    clk = 1'b0;
    rst_n = 1'b0;
    block_mode = 1'b0;
    n_tests = 0;
    n_fail = 0;
    hs_fall = 0; vs_fall = 0; de_rise = 0; fs_last = 0; fs_first = 0;
    p_hs = 1'b1; p_vs = 1'b1; p_de = 1'b0;

    repeat (10) begin
      @(negedge clk);
      check_reset("rst");
    end
    rst_n = 1'b1;

    // Two full frames (red, then the block pattern) and into frame 2.
    for (int unsigned c = 1; c <= C_RST; c++) begin
      @(negedge clk);
      if (c == C_SWITCH) block_mode = 1'b1;
      check_cycle(c);
      if (p_hs && !hs) begin
        if (hs_fall != 0) check("hs_period", c - hs_fall, 32'd3200);
        hs_fall = c;
      end
      if (!p_hs && hs) check("hs_low", c - hs_fall, 32'd384);
      if (p_vs && !vs) begin
        if (vs_fall != 0) check("vs_period", c - vs_fall, 32'd28800);
        vs_fall = c;
      end
      if (!p_vs && vs) check("vs_low", c - vs_fall, 32'd6400);
      if (!p_de && disp_en) de_rise = c;
      if (p_de && !disp_en) check("de_len", c - de_rise, 32'd2560);
      if (frame_start) begin
        if (fs_last != 0) check("fs_period", c - fs_last, 32'd28800);
        else check("fs_first", c, 32'd8);
        fs_last = c;
      end
      p_hs = hs; p_vs = vs; p_de = disp_en;
    end
    check("fs_seen", fs_last, 32'(8 + 2 * 28800));

    // Mid-line reset inside the visible window.
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset("mid");
    repeat (3) begin
      @(negedge clk);
      check_reset("mid_hold");
    end
    rst_n = 1'b1;
    for (int unsigned c = 1; c <= 40; c++) begin
      @(negedge clk);
      check_cycle(c);
      if (frame_start && fs_first == 0) fs_first = c;
    end
    check("fs_after_reset", fs_first, 32'd8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
